// File: rtl/mac_job_scheduler_pkg.sv
// Shared types and defaults for the MAC job scheduler slice.
package mac_package;

  localparam int MAC_SCHED_N_REQ = 4;
  localparam int MAC_SCHED_N_CTX = 2;

  typedef struct packed {
    logic [31:0] a_addr;
    logic [31:0] b_addr;
    logic [31:0] c_addr;
    logic [31:0] d_addr;
    logic [15:0] len;
    logic [4:0]  shift;
  } mac_job_t;

  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_START,
    SCHED_RUN
  } sched_state_t;

endpackage

// File: rtl/mac_job_scheduler_if.sv
// Request, dispatch and status bundle between the cores/MAC FSM (master) and the scheduler (slave).
interface mac_job_scheduler_if
  import mac_package::*;
#(
  parameter int N_REQ = MAC_SCHED_N_REQ,
  parameter int N_CTX = MAC_SCHED_N_CTX
);

  logic                     clear;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  mac_job_t [N_REQ-1:0]     req_job;
  logic                     start;
  mac_job_t                 job;
  logic                     done;
  logic [N_REQ-1:0]         evt;
  logic                     busy;
  logic [$clog2(N_CTX):0]   q_cnt;

  modport master (
    output clear, req_valid, req_job, done,
    input  req_ready, start, job, evt, busy, q_cnt
  );

  modport slave (
    input  clear, req_valid, req_job, done,
    output req_ready, start, job, evt, busy, q_cnt
  );

endinterface

// File: rtl/mac_job_scheduler_rr_arbiter.sv
// Round-robin grant: first valid requester at or after the pointer; pointer moves past each winner.
module mac_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear,
  input  logic             enable,
  input  logic [N_REQ-1:0] valid,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             granted
);

  logic [ID_W-1:0] rr_q;

  always_comb begin : grant_sel
    logic [ID_W-1:0] idx;
    idx       = '0;
    grant     = '0;
    grant_idx = '0;
    granted   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ID_W'((int'(rr_q) + i) % N_REQ);
      if (enable && !granted && valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        granted    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (clear) begin
      rr_q <= '0;
    end else if (granted) begin
      rr_q <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mac_job_scheduler.sv
// Arbitrates core job requests into a small FIFO and dispatches them one at a time to the MAC FSM.
//   state       | meaning
//   SCHED_IDLE  | nothing dispatched; retire len==0 heads, else launch head
//   SCHED_START | one-cycle start pulse with head descriptor
//   SCHED_RUN   | waiting for done from the MAC FSM
module mac_job_scheduler
  import mac_package::*;
#(
  parameter int N_REQ = MAC_SCHED_N_REQ,
  parameter int N_CTX = MAC_SCHED_N_CTX,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input logic                clk_i,
  input logic                rst_ni,
  mac_job_scheduler_if.slave bus
);

  localparam int PTR_W = $clog2(N_CTX);

  typedef struct packed {
    mac_job_t        job;
    logic [ID_W-1:0] owner;
  } entry_t;

  entry_t           mem [N_CTX];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, push, pop;
  logic [ID_W-1:0]  gnt_idx;
  sched_state_t     state_q, state_d;
  logic [N_REQ-1:0] evt_q, evt_d;

  assign full  = (count == (PTR_W+1)'(N_CTX));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  mac_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear     (bus.clear),
    .enable    (!full),
    .valid     (bus.req_valid),
    .grant     (bus.req_ready),
    .grant_idx (gnt_idx),
    .granted   (push)
  );

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{job: bus.req_job[gnt_idx], owner: gnt_idx};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    evt_d   = '0;
    case (state_q)
      SCHED_IDLE: begin
        if (!empty) begin
          if (head.job.len == '0) begin
            pop               = 1'b1;
            evt_d[head.owner] = 1'b1;
          end else begin
            state_d = SCHED_START;
          end
        end
      end
      SCHED_START: state_d = SCHED_RUN;
      SCHED_RUN: begin
        if (bus.done) begin
          pop               = 1'b1;
          evt_d[head.owner] = 1'b1;
          state_d           = SCHED_IDLE;
        end
      end
      default: state_d = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SCHED_IDLE;
      evt_q   <= '0;
    end else if (bus.clear) begin
      state_q <= SCHED_IDLE;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      evt_q   <= evt_d;
    end
  end

  assign bus.start = (state_q == SCHED_START);
  assign bus.job   = (state_q != SCHED_IDLE) ? head.job : '0;
  assign bus.evt   = evt_q;
  assign bus.busy  = (state_q != SCHED_IDLE) || !empty;
  assign bus.q_cnt = count;

endmodule

// File: tb/tb_mac_job_scheduler.sv
// Directed scoreboard bench: stimulus queues expected dispatches/events, a monitor pops and compares.
module tb_mac_job_scheduler;
  import mac_package::*;

  localparam int N_REQ = 4;
  localparam int N_CTX = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_job_scheduler_if #(.N_REQ(N_REQ), .N_CTX(N_CTX)) bus ();

  mac_job_scheduler #(.N_REQ(N_REQ), .N_CTX(N_CTX)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int evt_cnt  = 0;
  int start_cnt = 0;
  int evt_cyc [N_REQ];
  int acc_cyc [N_REQ];
  int done_q [$];
  mac_job_t         exp_start [$];
  logic [N_REQ-1:0] exp_evt [$];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic mac_job_t mk(input int core, input int len);
    mac_job_t j;
    j.a_addr = 32'h1000_0000 + 32'(core);
    j.b_addr = 32'h2000_0000 + 32'(core * 16);
    j.c_addr = 32'h3000_0000 + 32'(len);
    j.d_addr = 32'h4000_0000 + 32'(core * 256 + len);
    j.len    = 16'(len);
    j.shift  = 5'(core + 3);
    return j;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bus.start) begin
        start_cnt++;
        if (exp_start.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_start: job %0h with none expected", bus.job);
        end else begin
          check("start_job", 256'(bus.job), 256'(exp_start.pop_front()));
        end
      end
      if (bus.evt != '0) begin
        evt_cnt++;
        for (int i = 0; i < N_REQ; i++) if (bus.evt[i]) evt_cyc[i] = cyc;
        if (exp_evt.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_evt: got %b with none expected", bus.evt);
        end else begin
          check("evt_owner", 256'(bus.evt), 256'(exp_evt.pop_front()));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    next_cycle();
    bus.clear = 1'b0;
  endtask

  task automatic reset_logs();
    for (int i = 0; i < N_REQ; i++) begin
      acc_cyc[i] = -1;
      evt_cyc[i] = -1;
    end
    done_q.delete();
  endtask

  // Cores drop valid once accepted; MAC model raises done run_len cycles after start.
  task automatic run_jobs(input int run_len, input int n_evt, input int budget);
    int done_at;
    int n;
    int goal;
    logic [N_REQ-1:0] acc;
    done_at = -1;
    n       = 0;
    goal    = evt_cnt + n_evt;
    while (evt_cnt < goal && n < budget) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      for (int i = 0; i < N_REQ; i++) if (acc[i]) acc_cyc[i] = cyc;
      if (bus.done) done_q.push_back(cyc);
      if (bus.start) done_at = cyc + run_len;
      n_checks++;
      if (int'(bus.q_cnt) > N_CTX) begin
        n_fail++;
        $display("FAIL q_cnt_bound: got %0d limit %0d", bus.q_cnt, N_CTX);
      end
      next_cycle();
      bus.req_valid &= ~acc;
      bus.done = (cyc == done_at);
      n++;
    end
    bus.done = 1'b0;
    n_checks++;
    if (evt_cnt < goal) begin
      n_fail++;
      $display("FAIL run_timeout: got %0d events expected %0d", evt_cnt, goal);
    end
  endtask

  task automatic clear_mid_run(input bit use_reset);
    mac_job_t ja, jb;
    ja = mk(0, 5);
    jb = mk(1, 5);
    do_clear();
    exp_start.push_back(ja);
    bus.req_job[0] = ja;
    bus.req_job[1] = jb;
    bus.req_valid  = 4'b0011;
    @(negedge clk);
    next_cycle();
    bus.req_valid = 4'b0010;
    @(negedge clk);
    next_cycle();
    bus.req_valid = 4'b0000;
    @(negedge clk);
    check("clr_start", 256'(bus.start), 256'(1'b1));
    next_cycle();
    @(negedge clk);
    check("clr_q_before", 256'(bus.q_cnt), 256'(2));
    next_cycle();
    if (use_reset) begin
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_q_during", 256'(bus.q_cnt), 256'(0));
    end else begin
      bus.clear = 1'b1;
      bus.done  = 1'b1;
      @(negedge clk);
    end
    next_cycle();
    rst_n     = 1'b1;
    bus.clear = 1'b0;
    bus.done  = 1'b0;
    @(negedge clk);
    check("clr_q_after", 256'(bus.q_cnt), 256'(0));
    check("clr_busy_after", 256'(bus.busy), 256'(0));
    check("clr_evt_cancel", 256'(bus.evt), 256'(0));
    check("clr_job_after", 256'(bus.job), 256'(0));
    next_cycle();
    bus.done = 1'b1;
    next_cycle();
    bus.done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("clr_late_done", 256'(bus.evt), 256'(0));
      next_cycle();
    end
    // Pointer must be back at 0: with cores 1 and 3 valid, core 1 wins; clear also drops the accept.
    bus.req_job[3] = mk(3, 5);
    bus.req_valid  = 4'b1010;
    bus.clear      = 1'b1;
    @(negedge clk);
    check("clr_rr_reset", 256'(bus.req_ready), 256'(4'b0010));
    next_cycle();
    bus.clear     = 1'b0;
    bus.req_valid = 4'b0000;
    @(negedge clk);
    check("clr_accept_dropped", 256'(bus.q_cnt), 256'(0));
    next_cycle();
  endtask

  initial begin
    mac_job_t j [N_REQ];
    int t0;
    int s0;
    bus.clear     = 1'b0;
    bus.req_valid = '0;
    bus.done      = 1'b0;
    for (int i = 0; i < N_REQ; i++) bus.req_job[i] = '0;
    reset_logs();

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 256'(bus.req_ready), 256'(0));
    check("rst_start", 256'(bus.start), 256'(0));
    check("rst_job", 256'(bus.job), 256'(0));
    check("rst_evt", 256'(bus.evt), 256'(0));
    check("rst_busy", 256'(bus.busy), 256'(0));
    check("rst_q_cnt", 256'(bus.q_cnt), 256'(0));
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Single job, core 2, len 8
    j[2] = mk(2, 8);
    exp_start.push_back(j[2]);
    exp_evt.push_back(4'b0100);
    bus.req_job[2] = j[2];
    bus.req_valid  = 4'b0100;
    @(negedge clk);
    check("t1_ready", 256'(bus.req_ready), 256'(4'b0100));
    next_cycle();
    bus.req_valid = '0;
    @(negedge clk);
    check("t1_q_cnt_inc", 256'(bus.q_cnt), 256'(1));
    check("t1_no_early_start", 256'(bus.start), 256'(0));
    check("t1_busy", 256'(bus.busy), 256'(1));
    next_cycle();
    @(negedge clk);
    check("t1_start_t2", 256'(bus.start), 256'(1));
    repeat (13) next_cycle();
    bus.done = 1'b1;
    @(negedge clk);
    check("t1_job_held", 256'(bus.job), 256'(j[2]));
    check("t1_evt_not_comb", 256'(bus.evt), 256'(0));
    next_cycle();
    bus.done = 1'b0;
    @(negedge clk);
    check("t1_evt_t16", 256'(bus.evt), 256'(4'b0100));
    check("t1_q_cnt_dec", 256'(bus.q_cnt), 256'(0));
    next_cycle();
    @(negedge clk);
    check("t1_busy_t17", 256'(bus.busy), 256'(0));
    check("t1_job_idle", 256'(bus.job), 256'(0));
    next_cycle();

    // All four cores at once, includes the full-and-pop corner
    do_clear();
    reset_logs();
    for (int i = 0; i < N_REQ; i++) begin
      j[i] = mk(i, 2 + i);
      bus.req_job[i] = j[i];
      exp_start.push_back(j[i]);
    end
    exp_evt.push_back(4'b0001);
    exp_evt.push_back(4'b0010);
    exp_evt.push_back(4'b0100);
    exp_evt.push_back(4'b1000);
    t0 = cyc;
    bus.req_valid = 4'b1111;
    run_jobs(3, 4, 80);
    check("t2_acc0", 256'(acc_cyc[0]), 256'(t0));
    check("t2_acc1", 256'(acc_cyc[1]), 256'(t0 + 1));
    check("t2_acc2_after_pop", 256'(acc_cyc[2]), 256'(done_q[0] + 1));
    check("t2_acc3_after_pop", 256'(acc_cyc[3]), 256'(done_q[1] + 1));
    check("t2_evt_latency", 256'(evt_cyc[0]), 256'(done_q[0] + 1));

    // Fairness: core 0 held valid, core 3 requests once
    do_clear();
    reset_logs();
    j[0] = mk(0, 3);
    j[3] = mk(3, 3);
    bus.req_job[0] = j[0];
    bus.req_job[3] = j[3];
    exp_start.push_back(j[0]);
    exp_start.push_back(j[3]);
    exp_evt.push_back(4'b0001);
    exp_evt.push_back(4'b1000);
    bus.req_valid = 4'b1001;
    @(negedge clk);
    check("fair_first", 256'(bus.req_ready), 256'(4'b0001));
    next_cycle();
    @(negedge clk);
    check("fair_core3_second", 256'(bus.req_ready), 256'(4'b1000));
    next_cycle();
    bus.req_valid = '0;
    run_jobs(2, 2, 40);

    // len==0 job behind a len==4 job
    do_clear();
    reset_logs();
    j[0] = mk(0, 4);
    j[1] = mk(1, 0);
    bus.req_job[0] = j[0];
    bus.req_job[1] = j[1];
    exp_start.push_back(j[0]);
    exp_evt.push_back(4'b0001);
    exp_evt.push_back(4'b0010);
    s0 = start_cnt;
    bus.req_valid = 4'b0011;
    run_jobs(3, 2, 40);
    repeat (3) next_cycle();
    check("z_single_start", 256'(start_cnt - s0), 256'(1));
    check("z_evt_follow", 256'(evt_cyc[1]), 256'(evt_cyc[0] + 1));

    // Flush mid-run via clear, then via reset
    clear_mid_run(1'b0);
    clear_mid_run(1'b1);

    repeat (3) next_cycle();
    check("sb_start_drained", 256'(exp_start.size()), 256'(0));
    check("sb_evt_drained", 256'(exp_evt.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
